// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// uart_tx_param : parametrised UART transmitter with valid/ready input FIFO
// Revision 1.0
// ============================================================================
module uart_tx_param #(
   parameter int CLK_DIV    = 868,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset_b,
   input  logic [DATA_BITS-1:0]        tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        tx_out,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);
   localparam logic [15:0]   DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic          PAR_INIT  = (PARITY_ODD != 0);
   localparam logic          HAS_PAR   = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] head;

   // No full-bypass: a pop on a full edge does not open the input that cycle.
   assign tx_ready = (fifo_count != DEPTH);
   assign push     = tx_valid && tx_ready;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   // ---------------------------------------------------------------- FSM
   state_t               state, state_nxt;
   logic [15:0]          baud_cnt, baud_nxt;
   logic [3:0]           bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shift_reg, shift_nxt;
   logic                 parity_bit, parity_nxt;
   logic                 tx_nxt;
   logic                 baud_tick;

   assign baud_tick = (baud_cnt == DIV_LAST);
   assign busy      = (state != S_IDLE) || (fifo_count != '0);

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state      <= S_IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         tx_out     <= 1'b1;
      end else begin
         state      <= state_nxt;
         baud_cnt   <= baud_nxt;
         bit_cnt    <= bit_nxt;
         shift_reg  <= shift_nxt;
         parity_bit <= parity_nxt;
         tx_out     <= tx_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      baud_nxt   = baud_cnt;
      bit_nxt    = bit_cnt;
      shift_nxt  = shift_reg;
      parity_nxt = parity_bit;
      pop        = 1'b0;
      tx_nxt     = 1'b1;

      if (state != S_IDLE) begin
         baud_nxt = baud_tick ? 16'd0 : baud_cnt + 16'd1;
      end

      case (state)
         S_IDLE: begin
            if (fifo_count != '0) begin
               pop        = 1'b1;
               shift_nxt  = head;
               parity_nxt = (^head) ^ PAR_INIT;
               baud_nxt   = '0;
               bit_nxt    = '0;
               state_nxt  = S_START;
            end
         end
         S_START: begin
            if (baud_tick) begin
               bit_nxt   = '0;
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               shift_nxt = {1'b1, shift_reg[DATA_BITS-1:1]};
               if (bit_cnt == DATA_LAST) begin
                  bit_nxt   = '0;
                  state_nxt = HAS_PAR ? S_PARITY : S_STOP;
               end else begin
                  bit_nxt = bit_cnt + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (baud_tick) begin
               bit_nxt   = '0;
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               if (bit_cnt != STOP_LAST) begin
                  bit_nxt = bit_cnt + 4'd1;
               end else if (fifo_count != '0) begin
                  // Chain straight into the next frame with no idle cycle.
                  pop        = 1'b1;
                  shift_nxt  = head;
                  parity_nxt = (^head) ^ PAR_INIT;
                  bit_nxt    = '0;
                  state_nxt  = S_START;
               end else begin
                  bit_nxt   = '0;
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // The pin register follows the state being entered so it changes on the same edge.
      case (state_nxt)
         S_START:  tx_nxt = 1'b0;
         S_DATA:   tx_nxt = shift_nxt[0];
         S_PARITY: tx_nxt = parity_nxt;
         default:  tx_nxt = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// Testbench for uart_tx_param: four configurations checked against a
// bit-level line model built from frame rules.
module tb_uart_tx_param;

   logic            clk;
   logic            reset_b;
   logic [3:0][8:0] dat;
   logic [3:0]      valid;
   wire  [3:0]      rdy;
   wire  [3:0]      txo;
   wire  [3:0]      bsy;
   wire  [3:0][2:0] cnt;

   int cfg_div  [4] = '{4, 4, 4, 2};
   int cfg_bits [4] = '{8, 7, 7, 9};
   int cfg_pen  [4] = '{0, 1, 1, 0};
   int cfg_podd [4] = '{0, 0, 1, 0};
   int cfg_stop [4] = '{1, 2, 2, 1};

   int errors = 0;
   int checks = 0;

   bit         exp_line [$];
   logic [8:0] sw [6];

   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .reset_b(reset_b), .tx_data(dat[0][7:0]), .tx_valid(valid[0]),
      .tx_ready(rdy[0]), .tx_out(txo[0]), .busy(bsy[0]), .fifo_count(cnt[0]));

   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset_b(reset_b), .tx_data(dat[1][6:0]), .tx_valid(valid[1]),
      .tx_ready(rdy[1]), .tx_out(txo[1]), .busy(bsy[1]), .fifo_count(cnt[1]));

   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
      .clk(clk), .reset_b(reset_b), .tx_data(dat[2][6:0]), .tx_valid(valid[2]),
      .tx_ready(rdy[2]), .tx_out(txo[2]), .busy(bsy[2]), .fifo_count(cnt[2]));

   uart_tx_param #(.CLK_DIV(2), .DATA_BITS(9), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut_d (
      .clk(clk), .reset_b(reset_b), .tx_data(dat[3]), .tx_valid(valid[3]),
      .tx_ready(rdy[3]), .tx_out(txo[3]), .busy(bsy[3]), .fifo_count(cnt[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Appends one frame's line levels, one entry per clock cycle.
   function automatic void add_frame(input int d, input logic [8:0] w);
      bit bits_q [$];
      bit p;
      p = bit'(cfg_podd[d]);
      bits_q.push_back(1'b0);
      for (int i = 0; i < cfg_bits[d]; i++) begin
         bits_q.push_back(w[i]);
         p ^= w[i];
      end
      if (cfg_pen[d] != 0) bits_q.push_back(p);
      for (int i = 0; i < cfg_stop[d]; i++) bits_q.push_back(1'b1);
      foreach (bits_q[i])
         for (int j = 0; j < cfg_div[d]; j++) exp_line.push_back(bits_q[i]);
   endfunction

   function automatic logic [8:0] rand_word(input int d);
      logic [8:0] w;
      w = 9'($urandom);
      w &= 9'((1 << cfg_bits[d]) - 1);
      return w;
   endfunction

   task automatic send_one(input int d, input logic [8:0] w);
      exp_line.delete();
      add_frame(d, w);
      dat[d]   = w;
      valid[d] = 1'b1;
      step();
      valid[d] = 1'b0;
      chk("push_cnt", 32'(cnt[d]), 1);
      chk("push_idle", 32'(txo[d]), 1);
      chk("push_busy", 32'(bsy[d]), 1);
      for (int k = 0; k < exp_line.size(); k++) begin
         step();
         chk("line", 32'(txo[d]), 32'(exp_line[k]));
      end
      step();
      chk("end_busy", 32'(bsy[d]), 0);
      chk("end_txo", 32'(txo[d]), 1);
      chk("end_cnt", 32'(cnt[d]), 0);
   endtask

   // Holds tx_valid high over six words on dut_a; FIFO occupancy and line are modelled per cycle.
   task automatic stream();
      int idx;
      int mcnt;
      int flen;
      bit wp;
      exp_line.delete();
      for (int i = 0; i < 6; i++) add_frame(0, sw[i]);
      flen     = exp_line.size() / 6;
      idx      = 0;
      mcnt     = 0;
      dat[0]   = sw[0];
      valid[0] = 1'b1;
      for (int s = 1; s <= 2 + 6 * flen; s++) begin
         wp = valid[0] && (mcnt != 4);
         chk("ready", 32'(rdy[0]), 32'(mcnt != 4));
         step();
         mcnt += int'(wp);
         if (s >= 2 && ((s - 2) % flen) == 0 && ((s - 2) / flen) < 6) mcnt--;
         chk("count", 32'(cnt[0]), 32'(mcnt));
         if (s >= 2 && (s - 2) < 6 * flen)
            chk("stream_line", 32'(txo[0]), 32'(exp_line[s - 2]));
         else
            chk("stream_idle", 32'(txo[0]), 1);
         if (wp) begin
            idx++;
            if (idx < 6) dat[0] = sw[idx];
            else valid[0] = 1'b0;
         end
      end
      chk("stream_busy", 32'(bsy[0]), 0);
      chk("stream_words", 32'(idx), 6);
   endtask

   initial begin
      logic [8:0] w55;
      reset_b = 1'b0;
      valid   = '0;
      dat     = '0;
      w55     = 9'h055;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
         chk("rst_txo", 32'(txo[d]), 1);
         chk("rst_busy", 32'(bsy[d]), 0);
         chk("rst_cnt", 32'(cnt[d]), 0);
         chk("rst_ready", 32'(rdy[d]), 1);
      end
      @(negedge clk);
      reset_b = 1'b1;
      step();

      send_one(0, 9'h0A5);
      send_one(1, 9'h041);
      send_one(2, 9'h041);
      send_one(3, 9'h1FF);
      for (int r = 0; r < 3; r++)
         for (int d = 0; d < 4; d++) send_one(d, rand_word(d));

      for (int i = 0; i < 6; i++) sw[i] = 9'(i + 1);
      stream();
      for (int i = 0; i < 6; i++) sw[i] = rand_word(0);
      stream();

      // Reset during data bit 3 of 0x55 with two more words queued.
      dat[0]   = w55;
      valid[0] = 1'b1;
      step();
      dat[0] = rand_word(0);
      step();
      dat[0] = rand_word(0);
      step();
      valid[0] = 1'b0;
      chk("rq_cnt", 32'(cnt[0]), 2);
      repeat (15) step();
      chk("rq_bit3", 32'(txo[0]), 32'(w55[3]));
      #2 reset_b = 1'b0;
      #1;
      chk("mid_rst_txo", 32'(txo[0]), 1);
      chk("mid_rst_cnt", 32'(cnt[0]), 0);
      chk("mid_rst_busy", 32'(bsy[0]), 0);
      chk("mid_rst_ready", 32'(rdy[0]), 1);
      @(negedge clk);
      @(negedge clk);
      reset_b = 1'b1;
      for (int k = 0; k < 50; k++) begin
         step();
         chk("post_rst_txo", 32'(txo[0]), 1);
         chk("post_rst_busy", 32'(bsy[0]), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
